sme_param: RTL and testbench
============================

Name: sme_param

Overview:
- Parametrised string-matching engine: the successor of the fixed 32-char / 8-char matcher.
- Stores one target string and one pattern, each streamed in byte-serially, then scans the string for the pattern.
- Pattern syntax: '^' word-start anchor, '$' word-end anchor, '.' single-char wildcard.
- Adds a selectable first/last-match mode, a busy flag, overflow saturation, and a deterministic one-candidate-per-cycle scan.

Parameters:
- CHAR_W, 8: character width in bits.
- MAX_STR, 32: string buffer depth in characters.
- MAX_PAT, 8: pattern buffer depth in characters, anchors included.
- IDX_W, 5: match_index width; must satisfy 2^IDX_W >= MAX_STR.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- chardata  in  CHAR_W  input character, sampled when isstring or ispattern is 1.
- isstring  in  1  chardata is a string character.
- ispattern  in  1  chardata is a pattern character; ignored when isstring=1.
- mode  in  1  0 = report lowest matching index; 1 = report highest. Sampled on the search-start cycle.
- busy  out  1  high while searching; string/pattern input is ignored while busy.
- valid  out  1  one-cycle result strobe.
- match  out  1  a match was found; meaningful only when valid=1.
- match_index  out  IDX_W  start index of the reported match in the string; 0 when match=0.

Behaviour:
- Reset: synchronous, active-high. Takes priority over every other event, including reset mid-search.
  - All outputs go to 0; state = IDLE.
  - String length and pattern length are cleared. Buffer contents are don't-care.
- States:
  - IDLE: wait for input.
  - LOAD_S: receiving string characters.
  - LOAD_P: receiving pattern characters.
  - SEARCH: scanning candidates.
  - DONE: result strobe.
- Loading the string:
  - A string burst is consecutive cycles with isstring=1.
  - The first character of a burst (entry to LOAD_S from any non-LOAD_S state) clears the string length and is stored at index 0.
  - Each accepted character stores at the current length, then the length increments.
  - Once length = MAX_STR, further characters are dropped and the length saturates.
- Loading the pattern: same rules with ispattern, LOAD_P and MAX_PAT.
- Pattern reuse and order:
  - A new pattern burst after DONE reuses the stored string.
  - A string burst immediately following a pattern burst leaves LOAD_P without searching; a new pattern is required.
- Search start:
  - Cycle T is the first cycle in LOAD_P with ispattern=0 and isstring=0.
  - At T: latch mode, decode anchors, and move to SEARCH.
  - Anchor decode: '^' is recognised only at pattern[0]; '$' only at pattern[plen-1].
  - Effective length L = plen minus the number of anchors present.
- Candidate scan in SEARCH:
  - One candidate start i is evaluated per cycle, starting at T+1.
  - i = 0 upward for mode 0; i = slen-L downward for mode 1.
  - Candidate i matches when all of the following hold:
    - all L effective characters are equal, or the pattern character is '.' (0x2E);
    - if '^' is present: i=0, or str[i-1]=0x20;
    - if '$' is present: i+L=slen, or str[i+L]=0x20.
  - Only candidates with 0 <= i <= slen-L are evaluated.
- Result:
  - DONE is entered the cycle after the first successful candidate or after the last candidate.
  - In DONE: valid=1, match and match_index set, busy=0, for exactly one cycle.
  - Latency, mode 0, hit at k: valid at T+2+k.
  - Latency, mode 1, hit at k: valid at T+2+(slen-L-k).
  - Latency, miss: valid at T+2+(slen-L).
- Degenerate cases:
  - If L=0, slen=0, or L>slen: valid at T+2 with match=0.
- Input handling across states:
  - busy=1 throughout SEARCH; isstring/ispattern are ignored there.
  - In DONE, input is accepted and starts LOAD_S or LOAD_P directly.
  - Otherwise DONE returns to IDLE.
- Datapath:
  - Comparisons are unsigned CHAR_W-bit equality.
  - Index arithmetic uses at least IDX_W+1 bits so that slen-L never wraps.

Test Plan:
- "hello world" (11 chars), pattern "wor", mode 0 -> valid at T+8, match=1, match_index=6.
- Same string, pattern "^w.r" -> match=1, idx=6. Pattern "^orl" -> match=0, idx=0.
- Same string, pattern "lo$" -> idx=3. Pattern "^hello$" -> idx=0. Pattern "hell$" -> match=0.
- Same string, pattern "o", mode 1 -> idx=7, valid at T+5. Mode 0 -> idx=4, valid at T+6.
- 40-char string with MAX_STR=32, pattern equal to chars 28..31 -> match idx=28; chars 32..39 are never matchable.
- Reset asserted mid-SEARCH -> valid/busy=0 on the next cycle, no stale strobe. A reload and search then succeed normally. Pattern "xyz" against "hello world" -> match=0.

Source files
------------

// File: rtl/sme_if.sv
// Handshake/bus bundle for the string-matching engine: character stream in, search result out.
interface sme_if #(
  parameter int CHAR_W = 8,
  parameter int IDX_W  = 5
);
  logic [CHAR_W-1:0] chardata;
  logic              isstring;
  logic              ispattern;
  logic              mode;
  logic              busy;
  logic              valid;
  logic              match;
  logic [IDX_W-1:0]  match_index;

  modport master (
    output chardata, isstring, ispattern, mode,
    input  busy, valid, match, match_index
  );

  modport slave (
    input  chardata, isstring, ispattern, mode,
    output busy, valid, match, match_index
  );
endinterface

// File: rtl/sme_param.sv
// Parametrised string matcher: byte-serial string and pattern load, then a one-candidate-per-cycle
// scan supporting '^'/'$' word anchors, '.' wildcard and lowest/highest match selection.
module sme_param #(
  parameter int CHAR_W  = 8,
  parameter int MAX_STR = 32,
  parameter int MAX_PAT = 8,
  parameter int IDX_W   = 5
) (
  input logic  clk,
  input logic  reset,
  sme_if.slave bus
);

  localparam int CNT_W  = IDX_W + 1;
  localparam int PCNT_W = $clog2(MAX_PAT + 1);
  localparam int STR_AW = (MAX_STR > 1) ? $clog2(MAX_STR) : 1;
  localparam int PAT_AW = (MAX_PAT > 1) ? $clog2(MAX_PAT) : 1;

  localparam logic [CHAR_W-1:0] CARET  = CHAR_W'(8'h5E);
  localparam logic [CHAR_W-1:0] DOLLAR = CHAR_W'(8'h24);
  localparam logic [CHAR_W-1:0] DOT    = CHAR_W'(8'h2E);
  localparam logic [CHAR_W-1:0] SPACE  = CHAR_W'(8'h20);

  typedef enum logic [2:0] {IDLE, LOAD_S, LOAD_P, SEARCH, DONE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   slen_q, slen_d;
  logic [PCNT_W-1:0]  plen_q, plen_d;
  logic [CHAR_W-1:0]  str_q [MAX_STR];
  logic [CHAR_W-1:0]  str_d [MAX_STR];
  logic [CHAR_W-1:0]  pat_q [MAX_PAT];
  logic [CHAR_W-1:0]  pat_d [MAX_PAT];
  logic               mode_q, mode_d;
  logic               caret_q, caret_d;
  logic               dollar_q, dollar_d;
  logic [PCNT_W-1:0]  eff_len_q, eff_len_d;
  logic [CNT_W-1:0]   cand_q, cand_d;
  logic               match_q, match_d;
  logic [IDX_W-1:0]   idx_q, idx_d;

  logic [CNT_W-1:0]   len_ext;
  logic [CNT_W-1:0]   last_start;
  logic               degenerate;
  logic               last_cand;
  logic               chars_ok;
  logic               caret_ok;
  logic               dollar_ok;
  logic               cand_hit;
  logic [CNT_W-1:0]   s_idx;
  logic [PCNT_W-1:0]  p_idx;
  logic [CNT_W-1:0]   prev_idx;
  logic [CNT_W-1:0]   end_idx;

  logic [CNT_W-1:0]   wr_s;
  logic [PCNT_W-1:0]  wr_p;
  logic [PCNT_W-1:0]  last_p;
  logic               t_caret;
  logic               t_dollar;
  logic [PCNT_W-1:0]  t_eff;

  assign len_ext    = CNT_W'(eff_len_q);
  assign last_start = slen_q - len_ext;
  assign degenerate = (eff_len_q == '0) || (slen_q == '0) || (len_ext > slen_q);
  assign last_cand  = mode_q ? (cand_q == '0) : (cand_q == last_start);

  // Evaluate the current candidate start against every effective pattern character and both anchors.
  always_comb begin
    chars_ok = 1'b1;
    s_idx    = '0;
    p_idx    = '0;
    for (int j = 0; j < MAX_PAT; j++) begin
      if (PCNT_W'(j) < eff_len_q) begin
        s_idx = cand_q + CNT_W'(j);
        p_idx = PCNT_W'(j) + PCNT_W'(caret_q);
        if ((pat_q[p_idx[PAT_AW-1:0]] != DOT) &&
            (pat_q[p_idx[PAT_AW-1:0]] != str_q[s_idx[STR_AW-1:0]])) begin
          chars_ok = 1'b0;
        end
      end
    end
    prev_idx  = cand_q - CNT_W'(1);
    end_idx   = cand_q + len_ext;
    caret_ok  = !caret_q || (cand_q == '0) || (str_q[prev_idx[STR_AW-1:0]] == SPACE);
    dollar_ok = !dollar_q || (end_idx == slen_q) || (str_q[end_idx[STR_AW-1:0]] == SPACE);
    cand_hit  = chars_ok && caret_ok && dollar_ok;
  end

  always_comb begin
    state_d   = state_q;
    slen_d    = slen_q;
    plen_d    = plen_q;
    str_d     = str_q;
    pat_d     = pat_q;
    mode_d    = mode_q;
    caret_d   = caret_q;
    dollar_d  = dollar_q;
    eff_len_d = eff_len_q;
    cand_d    = cand_q;
    match_d   = match_q;
    idx_d     = idx_q;
    wr_s      = '0;
    wr_p      = '0;
    last_p    = '0;
    t_caret   = 1'b0;
    t_dollar  = 1'b0;
    t_eff     = '0;

    case (state_q)
      SEARCH: begin
        if (degenerate) begin
          state_d = DONE;
          match_d = 1'b0;
          idx_d   = '0;
        end else if (cand_hit) begin
          state_d = DONE;
          match_d = 1'b1;
          idx_d   = cand_q[IDX_W-1:0];
        end else if (last_cand) begin
          state_d = DONE;
          match_d = 1'b0;
          idx_d   = '0;
        end else begin
          cand_d = mode_q ? (cand_q - CNT_W'(1)) : (cand_q + CNT_W'(1));
        end
      end

      default: begin
        if (bus.isstring) begin
          // A burst entered from any other state restarts the buffer at index 0.
          state_d = LOAD_S;
          wr_s    = (state_q == LOAD_S) ? slen_q : '0;
          if (wr_s < CNT_W'(MAX_STR)) begin
            str_d[wr_s[STR_AW-1:0]] = bus.chardata;
            slen_d = wr_s + CNT_W'(1);
          end else begin
            slen_d = wr_s;
          end
        end else if (bus.ispattern) begin
          state_d = LOAD_P;
          wr_p    = (state_q == LOAD_P) ? plen_q : '0;
          if (wr_p < PCNT_W'(MAX_PAT)) begin
            pat_d[wr_p[PAT_AW-1:0]] = bus.chardata;
            plen_d = wr_p + PCNT_W'(1);
          end else begin
            plen_d = wr_p;
          end
        end else if (state_q == LOAD_P) begin
          last_p    = plen_q - PCNT_W'(1);
          t_caret   = (plen_q != '0) && (pat_q[0] == CARET);
          t_dollar  = (plen_q != '0) && (pat_q[last_p[PAT_AW-1:0]] == DOLLAR);
          t_eff     = plen_q - PCNT_W'(t_caret) - PCNT_W'(t_dollar);
          caret_d   = t_caret;
          dollar_d  = t_dollar;
          eff_len_d = t_eff;
          mode_d    = bus.mode;
          cand_d    = bus.mode ? (slen_q - CNT_W'(t_eff)) : '0;
          state_d   = SEARCH;
        end else if ((state_q == LOAD_S) || (state_q == DONE)) begin
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      slen_q    <= '0;
      plen_q    <= '0;
      mode_q    <= 1'b0;
      caret_q   <= 1'b0;
      dollar_q  <= 1'b0;
      eff_len_q <= '0;
      cand_q    <= '0;
      match_q   <= 1'b0;
      idx_q     <= '0;
    end else begin
      state_q   <= state_d;
      slen_q    <= slen_d;
      plen_q    <= plen_d;
      mode_q    <= mode_d;
      caret_q   <= caret_d;
      dollar_q  <= dollar_d;
      eff_len_q <= eff_len_d;
      cand_q    <= cand_d;
      match_q   <= match_d;
      idx_q     <= idx_d;
    end
  end

  // Buffer contents are don't-care after reset, so they carry no reset term.
  always_ff @(posedge clk) begin
    str_q <= str_d;
    pat_q <= pat_d;
  end

  assign bus.busy        = (state_q == SEARCH);
  assign bus.valid       = (state_q == DONE);
  assign bus.match       = (state_q == DONE) && match_q;
  assign bus.match_index = (state_q == DONE) ? idx_q : '0;

endmodule

// File: tb/tb_sme_param.sv
// Directed bench for sme_param: expected results are queued at search start and popped when valid rises.
module tb_sme_param;

  localparam int CHAR_W  = 8;
  localparam int MAX_STR = 32;
  localparam int MAX_PAT = 8;
  localparam int IDX_W   = 5;

  typedef struct {
    logic             exp_match;
    logic [IDX_W-1:0] exp_idx;
    int               exp_lat;
    string            tag;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   t0 = 0;
  int   compare_cnt = 0;
  int   mismatch_cnt = 0;
  exp_t sb[$];

  sme_if #(.CHAR_W(CHAR_W), .IDX_W(IDX_W)) bus();

  sme_param #(
    .CHAR_W (CHAR_W),
    .MAX_STR(MAX_STR),
    .MAX_PAT(MAX_PAT),
    .IDX_W  (IDX_W)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compare_cnt++;
    assert (obs === exp) else begin
      mismatch_cnt++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input string s, input bit is_pat);
    for (int i = 0; i < s.len(); i++) begin
      bus.isstring  = !is_pat;
      bus.ispattern = is_pat;
      bus.chardata  = s[i];
      tick();
    end
    bus.isstring  = 1'b0;
    bus.ispattern = 1'b0;
  endtask

  // Loads a pattern, starts the search and scores the result; chain leaves the bench in the DONE cycle.
  task automatic launch(input string pat, input bit m, input bit exp_m, input int exp_idx,
                        input int exp_lat, input string tag, input bit chain);
    exp_t e;
    bit   got;
    applyStimulus(pat, 1'b1);
    bus.mode = m;
    t0 = cyc;
    sb.push_back('{exp_m, IDX_W'(exp_idx), exp_lat, tag});
    tick();
    bus.mode = 1'b0;
    checkOutput({tag, " busy"}, 32'(bus.busy), 32'd1);
    got = 1'b0;
    for (int n = 0; n < 80 && !got; n++) begin
      if (bus.valid) got = 1'b1;
      else tick();
    end
    e = sb.pop_front();
    checkOutput({e.tag, " seen"}, 32'(got), 32'd1);
    if (got) begin
      checkOutput({e.tag, " match"}, 32'(bus.match), 32'(e.exp_match));
      checkOutput({e.tag, " index"}, 32'(bus.match_index), 32'(e.exp_idx));
      checkOutput({e.tag, " latency"}, 32'(cyc - t0), 32'(e.exp_lat));
      checkOutput({e.tag, " busy in done"}, 32'(bus.busy), 32'd0);
      if (!chain) begin
        tick();
        checkOutput({e.tag, " strobe width"}, 32'(bus.valid), 32'd0);
      end
    end
  endtask

  task automatic quietWindow(input int n_cycles, input string tag);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < n_cycles; n++) begin
      tick();
      if (bus.valid) seen = 1'b1;
    end
    checkOutput(tag, 32'(seen), 32'd0);
  endtask

  initial begin
    reset         = 1'b1;
    bus.chardata  = '0;
    bus.isstring  = 1'b0;
    bus.ispattern = 1'b0;
    bus.mode      = 1'b0;
    tick();
    tick();
    checkOutput("reset valid", 32'(bus.valid), 32'd0);
    checkOutput("reset busy", 32'(bus.busy), 32'd0);
    checkOutput("reset match", 32'(bus.match), 32'd0);
    checkOutput("reset index", 32'(bus.match_index), 32'd0);
    reset = 1'b0;
    tick();

    applyStimulus("hello world", 1'b0);
    launch("wor",         1'b0, 1'b1, 6, 8,  "wor",      1'b0);
    launch("^w.r",        1'b0, 1'b1, 6, 8,  "^w.r",     1'b0);
    launch("^orl",        1'b0, 1'b0, 0, 10, "^orl",     1'b0);
    launch("lo$",         1'b0, 1'b1, 3, 5,  "lo$",      1'b0);
    launch("^hello$",     1'b0, 1'b1, 0, 2,  "^hello$",  1'b0);
    launch("hell$",       1'b0, 1'b0, 0, 9,  "hell$",    1'b0);
    launch("o",           1'b1, 1'b1, 7, 5,  "o last",   1'b1);
    launch("o",           1'b0, 1'b1, 4, 6,  "o first",  1'b0);
    launch("^$",          1'b0, 1'b0, 0, 2,  "empty L",  1'b0);
    launch("hello wor!!", 1'b1, 1'b1, 0, 5,  "pat sat",  1'b0);

    // A string burst right after a pattern burst must not trigger a search.
    applyStimulus("wor", 1'b1);
    applyStimulus("hello world", 1'b0);
    quietWindow(14, "no search after reorder");
    launch("wor",         1'b0, 1'b1, 6, 8,  "reorder",  1'b0);

    applyStimulus("ABCDEFGHIJKLMNOPQRSTUVWXYZabcdefghijklmn", 1'b0);
    launch("cdef",        1'b0, 1'b1, 28, 30, "str sat first", 1'b0);
    launch("cdef",        1'b1, 1'b1, 28, 2,  "str sat last",  1'b0);
    launch("ghij",        1'b0, 1'b0, 0,  30, "dropped chars", 1'b0);

    applyStimulus("hi", 1'b0);
    launch("hello",       1'b0, 1'b0, 0, 2,  "L gt slen", 1'b0);

    applyStimulus("hello world", 1'b0);
    applyStimulus("o", 1'b1);
    tick();
    tick();
    checkOutput("mid search busy", 32'(bus.busy), 32'd1);
    reset = 1'b1;
    tick();
    checkOutput("reset mid valid", 32'(bus.valid), 32'd0);
    checkOutput("reset mid busy", 32'(bus.busy), 32'd0);
    reset = 1'b0;
    quietWindow(10, "no stale strobe");

    applyStimulus("hello world", 1'b0);
    launch("xyz",         1'b0, 1'b0, 0, 10, "xyz",       1'b0);
    launch("wor",         1'b0, 1'b1, 6, 8,  "wor again", 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_cnt, mismatch_cnt);
    $finish;
  end

endmodule
